// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } state_t;

  // Requester identifiers, also the encoding of the round-robin PRIO bit.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_RD_LAT = 1;

  // Wide enough to count down a read latency of 1..3 cycles.
  localparam int LAT_W = 2;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin selector; PRIO names who wins a tie and moves to the
// loser on every grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic winner
);

  logic prio;

  // Pick the winner: a lone requester wins, a tie goes to PRIO.
  always_comb begin
    if (req_a && req_b) begin
      winner = prio;
    end else if (req_b) begin
      winner = REQ_B;
    end else begin
      winner = REQ_A;
    end
  end

  // Hand priority to the loser whenever a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (update) begin
      prio <= ~winner;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// One access at a time; every output, including the RAM strobes, is registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              A_GNT,
  output logic              B_GNT,
  output logic              A_ERR,
  output logic              B_ERR,
  output logic              A_RVALID,
  output logic              B_RVALID,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  input  logic [DATA_W-1:0] RAM_DATA_OUT,
  output logic              RAM_RD,
  output logic              RAM_WR,
  output logic              RAM_CS
);

  state_t             state;
  state_t             next_state;
  logic               winner;
  logic               owner;
  logic               rd_pend;
  logic [LAT_W-1:0]   lat_cnt;
  logic               arb_fire;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               in_range;

  // Arbitration happens only in IDLE; requests seen elsewhere simply wait.
  assign arb_fire  = (state == IDLE) && (A_REQ || B_REQ);
  assign sel_we    = (winner == REQ_B) ? B_WE    : A_WE;
  assign sel_addr  = (winner == REQ_B) ? B_ADDR  : A_ADDR;
  assign sel_wdata = (winner == REQ_B) ? B_WDATA : A_WDATA;
  assign in_range  = sel_addr < ADDR_W'(DEPTH);

  rr_arb2 u_rr_arb2 (
    .clk    (CLK),
    .rst    (RST),
    .req_a  (A_REQ),
    .req_b  (B_REQ),
    .update (arb_fire),
    .winner (winner)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: ACCESS is one cycle, RDWAIT lasts RD_LAT cycles.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:    if (A_REQ || B_REQ) next_state = ACCESS;
      ACCESS:  next_state = rd_pend ? RDWAIT : IDLE;
      RDWAIT:  if (lat_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs: grant and strobes are launched at the arbitration
  // edge so they appear during ACCESS; read data is captured at the end of
  // RDWAIT and announced with RVALID in the following cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, independent of statement order.
      owner       <= REQ_A;
      rd_pend     <= 1'b0;
      lat_cnt     <= '0;
      A_GNT       <= 1'b0;
      B_GNT       <= 1'b0;
      A_ERR       <= 1'b0;
      B_ERR       <= 1'b0;
      A_RVALID    <= 1'b0;
      B_RVALID    <= 1'b0;
      RDATA       <= '0;
      RAM_ADDR    <= '0;
      RAM_DATA_IN <= '0;
      RAM_RD      <= 1'b0;
      RAM_WR      <= 1'b0;
      RAM_CS      <= 1'b0;
    end else begin
      A_GNT    <= 1'b0;
      B_GNT    <= 1'b0;
      A_ERR    <= 1'b0;
      B_ERR    <= 1'b0;
      A_RVALID <= 1'b0;
      B_RVALID <= 1'b0;
      RAM_RD   <= 1'b0;
      RAM_WR   <= 1'b0;
      RAM_CS   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_fire) begin
            owner   <= winner;
            rd_pend <= in_range && !sel_we;
            A_GNT   <= (winner == REQ_A);
            B_GNT   <= (winner == REQ_B);
            A_ERR   <= (winner == REQ_A) && !in_range;
            B_ERR   <= (winner == REQ_B) && !in_range;
            // Out-of-range accesses leave the RAM bus untouched.
            if (in_range) begin
              RAM_CS   <= 1'b1;
              RAM_WR   <= sel_we;
              RAM_RD   <= !sel_we;
              RAM_ADDR <= sel_addr;
              if (sel_we) RAM_DATA_IN <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          lat_cnt <= LAT_W'(RD_LAT - 1);
        end
        RDWAIT: begin
          if (lat_cnt == '0) begin
            RDATA    <= RAM_DATA_OUT;
            A_RVALID <= (owner == REQ_A);
            B_RVALID <= (owner == REQ_B);
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with RD_LAT=1 for the
// cycle-accurate scenarios, one with RD_LAT=3 for latency and a model-checked
// alternating A/B sequence. Both share the request inputs; the idle instance
// is held in reset and dut_sel picks which outputs are observed.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  logic a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

  logic a_gnt1, b_gnt1, a_err1, b_err1, a_rv1, b_rv1, rd1, wr1, cs1;
  logic [15:0] rdata1, raddr1, rdin1, dout1;
  logic a_gnt3, b_gnt3, a_err3, b_err3, a_rv3, b_rv3, rd3, wr3, cs3;
  logic [15:0] rdata3, raddr3, rdin3, dout3;

  logic dut_sel = 1'b0;
  wire a_gnt    = dut_sel ? a_gnt3 : a_gnt1;
  wire b_gnt    = dut_sel ? b_gnt3 : b_gnt1;
  wire a_err    = dut_sel ? a_err3 : a_err1;
  wire b_err    = dut_sel ? b_err3 : b_err1;
  wire a_rvalid = dut_sel ? a_rv3  : a_rv1;
  wire b_rvalid = dut_sel ? b_rv3  : b_rv1;
  wire ram_rd   = dut_sel ? rd3    : rd1;
  wire ram_wr   = dut_sel ? wr3    : wr1;
  wire ram_cs   = dut_sel ? cs3    : cs1;
  wire [15:0] rdata    = dut_sel ? rdata3 : rdata1;
  wire [15:0] ram_addr = dut_sel ? raddr3 : raddr1;
  wire [15:0] ram_din  = dut_sel ? rdin3  : rdin1;

  ram_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst1),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .A_GNT(a_gnt1), .B_GNT(b_gnt1), .A_ERR(a_err1), .B_ERR(b_err1),
    .A_RVALID(a_rv1), .B_RVALID(b_rv1), .RDATA(rdata1),
    .RAM_ADDR(raddr1), .RAM_DATA_IN(rdin1), .RAM_DATA_OUT(dout1),
    .RAM_RD(rd1), .RAM_WR(wr1), .RAM_CS(cs1)
  );

  ram_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst3),
    .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
    .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
    .A_GNT(a_gnt3), .B_GNT(b_gnt3), .A_ERR(a_err3), .B_ERR(b_err3),
    .A_RVALID(a_rv3), .B_RVALID(b_rv3), .RDATA(rdata3),
    .RAM_ADDR(raddr3), .RAM_DATA_IN(rdin3), .RAM_DATA_OUT(dout3),
    .RAM_RD(rd3), .RAM_WR(wr3), .RAM_CS(cs3)
  );

  // RAM models: data is valid exactly RD_LAT cycles after the RD strobe
  // cycle and reads as 0xDEAD at any other time.
  logic [15:0] mem1 [65536];
  logic        v1;
  logic [15:0] q1;
  always @(posedge clk) begin
    if (cs1 && wr1) mem1[raddr1] <= rdin1;
    v1 <= cs1 && rd1;
    q1 <= mem1[raddr1];
  end
  assign dout1 = v1 ? q1 : 16'hDEAD;

  logic [15:0] mem3 [65536];
  logic [2:0]  v3;
  logic [15:0] q3 [3];
  always @(posedge clk) begin
    if (cs3 && wr3) mem3[raddr3] <= rdin3;
    v3    <= {v3[1:0], cs3 && rd3};
    q3[0] <= mem3[raddr3];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign dout3 = v3[2] ? q3[2] : 16'hDEAD;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitors: RD/WR exclusivity, and no REQ dropped before its GNT.
  logic a_req_q = 1'b0, b_req_q = 1'b0, a_gnted = 1'b0, b_gnted = 1'b0;
  always @(negedge clk) begin
    check("rd_wr_excl", 32'(ram_rd & ram_wr), 0);
    if (a_req_q && !a_req) check("a_req_drop", 32'(a_gnted | a_gnt), 1);
    if (b_req_q && !b_req) check("b_req_drop", 32'(b_gnted | b_gnt), 1);
    if (a_req && !a_req_q) a_gnted <= a_gnt; else if (a_gnt) a_gnted <= 1'b1;
    if (b_req && !b_req_q) b_gnted <= b_gnt; else if (b_gnt) b_gnted <= 1'b1;
    a_req_q <= a_req;
    b_req_q <= b_req;
  end

  // One complete access from an idle arbiter: grant latency, error flag,
  // strobes, and for in-range reads the RVALID latency and returned data.
  task automatic access(input logic who, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata,
                        input int lat, input string tag);
    int   n;
    logic seen;
    logic exp_err;
    exp_err = (addr >= 16'd1024);
    if (who == REQ_A) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      tick();
      n++;
      seen = (who == REQ_A) ? a_gnt : b_gnt;
    end
    check({tag, "_gnt_lat"}, 32'(n), 1);
    check({tag, "_err"}, 32'((who == REQ_A) ? a_err : b_err), 32'(exp_err));
    if (exp_err) begin
      check({tag, "_strobe"}, 32'({ram_cs, ram_wr, ram_rd}), 0);
    end else begin
      check({tag, "_strobe"}, 32'({ram_cs, ram_wr, ram_rd}), 32'({1'b1, we, !we}));
      check({tag, "_addr"}, 32'(ram_addr), 32'(addr));
    end
    if (who == REQ_A) a_req = 1'b0; else b_req = 1'b0;
    if (!we && !exp_err) begin
      seen = 1'b0;
      while (!seen && n < 16) begin
        tick();
        n++;
        seen = (who == REQ_A) ? a_rvalid : b_rvalid;
      end
      check({tag, "_rd_lat"}, 32'(n), 32'(lat + 2));
      check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
    end else begin
      tick();
    end
  endtask

  logic [15:0] model [32];
  logic        seen_any;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        who, we;
    logic [15:0] addr, wd, exp;
    rst1 = 1'b1; rst3 = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_flags", 32'({a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid, ram_rd, ram_wr, ram_cs}), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", 32'(ram_din), 0);
    check("rst_rdata", 32'(rdata), 0);
    rst1 = 1'b0;

    // A writes 0x1234 to 0x0010.
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 16'h1234;
    tick();
    check("wr_gnt", 32'({a_gnt, b_gnt, a_err}), 'h4);
    check("wr_strobe", 32'({ram_cs, ram_wr, ram_rd}), 'h6);
    check("wr_addr", 32'(ram_addr), 'h0010);
    check("wr_din", 32'(ram_din), 'h1234);
    a_req = 1'b0;
    tick();
    check("wr_pulse_end", 32'({a_gnt, ram_cs, ram_wr}), 0);

    // A reads it back: RVALID three cycles after the REQ sample.
    a_req = 1'b1; a_we = 1'b0;
    tick();
    check("rd_gnt_strobe", 32'({a_gnt, ram_cs, ram_wr, ram_rd}), 'hD);
    a_req = 1'b0;
    tick();
    check("rd_wait", 32'({a_rvalid, ram_cs}), 0);
    tick();
    check("rd_rvalid", 32'({a_rvalid, b_rvalid}), 'h2);
    check("rd_rdata", 32'(rdata), 'h1234);
    tick();
    check("rd_rvalid_pulse", 32'(a_rvalid), 0);
    check("rd_rdata_hold", 32'(rdata), 'h1234);

    // Simultaneous requests after reset: A first, then B.
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0011; a_wdata = 16'hAAAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0012; b_wdata = 16'hBBBB;
    tick();
    check("sim_first", 32'({a_gnt, b_gnt}), 'h2);
    a_req = 1'b0;
    tick();
    check("sim_gap", 32'({a_gnt, b_gnt}), 0);
    tick();
    check("sim_second", 32'({a_gnt, b_gnt}), 'h1);
    check("sim_second_addr", 32'(ram_addr), 'h0012);
    b_req = 1'b0;
    tick();

    // Both held: grants alternate A, B, A, B.
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("alt_%0d", i), 32'({a_gnt, b_gnt}), (i % 2 == 0) ? 'h2 : 'h1);
      if (i == 2) a_req = 1'b0;
      if (i == 3) b_req = 1'b0;
      tick();
    end

    // Out of range: B reads 0x0400.
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0400;
    tick();
    check("oor_gnt_err", 32'({b_gnt, b_err, a_gnt, a_err}), 'hC);
    check("oor_no_cs", 32'({ram_cs, ram_rd, ram_wr}), 0);
    b_req = 1'b0;
    seen_any = 1'b0;
    repeat (4) begin
      tick();
      seen_any = seen_any | b_rvalid | b_err | ram_cs;
    end
    check("oor_quiet", 32'(seen_any), 0);

    // B requests during A's read: waits until after A_RVALID.
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    tick();
    check("rdq_a_gnt", 32'({a_gnt, b_gnt}), 'h2);
    a_req = 1'b0;
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0020; b_wdata = 16'h5555;
    check("rdq_wait", 32'({a_gnt, b_gnt, a_rvalid}), 0);
    tick();
    check("rdq_rvalid", 32'({a_rvalid, b_gnt}), 'h2);
    check("rdq_rdata", 32'(rdata), 'h1234);
    tick();
    check("rdq_b_gnt", 32'({b_gnt, ram_wr}), 'h3);
    check("rdq_rdata_keep", 32'(rdata), 'h1234);
    b_req = 1'b0;
    tick();

    // Reset in RDWAIT: read dropped, everything cleared, then normal service.
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020;
    tick();
    check("rmr_gnt", 32'(a_gnt), 1);
    a_req = 1'b0;
    tick();
    rst1 = 1'b1;
    tick();
    check("rmr_flags", 32'({a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid, ram_rd, ram_wr, ram_cs}), 0);
    check("rmr_ram_addr", 32'(ram_addr), 0);
    check("rmr_ram_din", 32'(ram_din), 0);
    check("rmr_rdata", 32'(rdata), 0);
    rst1 = 1'b0;
    seen_any = 1'b0;
    repeat (3) begin
      tick();
      seen_any = seen_any | a_rvalid;
    end
    check("rmr_no_rvalid", 32'(seen_any), 0);
    access(REQ_A, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1, "rmr_after");

    // RD_LAT=3 instance.
    rst1 = 1'b1;
    tick();
    dut_sel = 1'b1;
    rst3 = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      wd = 16'(i * 16'h0101 + 16'h0F00);
      access(i[0], 1'b1, 16'(i), wd, 16'h0000, 3, $sformatf("init%0d", i));
      model[i] = wd;
    end
    access(REQ_A, 1'b1, 16'h0005, 16'hCAFE, 16'h0000, 3, "l3_wr");
    model[5] = 16'hCAFE;
    access(REQ_B, 1'b0, 16'h0005, 16'h0000, 16'hCAFE, 3, "l3_rd");
    for (int i = 0; i < 100; i++) begin
      who  = i[0];
      we   = 1'($urandom_range(0, 1));
      addr = (i % 10 == 9) ? 16'h0400 + 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 31));
      wd   = 16'($urandom);
      exp  = (addr < 16'd1024) ? model[addr[4:0]] : 16'h0000;
      access(who, we, addr, wd, exp, 3, $sformatf("rnd%0d", i));
      if (we && addr < 16'd1024) model[addr[4:0]] = wd;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
